lzw_code_packer: RTL and testbench

- Parametrised successor to the fixed 13-bit LZW output register.
- Packs variable-width LZW codes (per-code width 1..MAX_CODE_W) MSB-first into OUT_W-bit output beats, using valid/ready handshakes on both sides.
- Supports explicit end-of-stream flush with zero padding and a last-beat marker.
- Sits between lzw_ctrl (code producer) and the IO RAM write port (beat consumer).

---
 rtl/lzw_pkg.sv | 25 ++
 rtl/lzw_code_packer_if.sv | 33 +++
 rtl/lzw_pack_acc.sv | 82 ++++++++
 rtl/lzw_code_packer.sv | 210 +++++++++++++++++++++
 tb/tb_lzw_code_packer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lzw_pkg.sv
// Shared definitions for the LZW code packer: FSM state encoding, default
// code width, fill-counter sizing and the parameter legality check.
// Optional terminator-code feature is controlled by LZW_PACK_EOS_CODE_EN.
package lzw_pkg;

    localparam int LZW_MAX_CODE_W = 13;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_EOS   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } lzw_state_e;

    // Width needed to count 0..acc_w held bits.
    function automatic int lzw_fill_w(input int acc_w);
        return $clog2(acc_w + 1);
    endfunction

    // The accumulator must hold a full beat plus the widest code at once.
    function automatic bit lzw_params_ok(input int max_code_w, input int out_w, input int acc_w);
        return (max_code_w >= 1) && (out_w >= 1) && (acc_w >= max_code_w + out_w);
    endfunction

endpackage

// File: rtl/lzw_code_packer_if.sv
// Code-in / beat-out handshake bundle for the LZW code packer.
// master: the surrounding system (code producer and beat consumer).
// slave : the packer itself.
interface lzw_code_packer_if
    import lzw_pkg::*;
#(
    parameter int MAX_CODE_W = LZW_MAX_CODE_W,
    parameter int OUT_W      = 8
);
    localparam int CW_W = $clog2(MAX_CODE_W + 1);

    logic                  code_valid;
    logic                  code_ready;
    logic [MAX_CODE_W-1:0] code_data;
    logic [CW_W-1:0]       code_width;
    logic                  flush_req;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic                  out_last;
    logic                  flush_done;

    modport master (
        output code_valid, code_data, code_width, flush_req, out_ready,
        input  code_ready, out_valid, out_data, out_last, flush_done
    );

    modport slave (
        input  code_valid, code_data, code_width, flush_req, out_ready,
        output code_ready, out_valid, out_data, out_last, flush_done
    );

endinterface

// File: rtl/lzw_pack_acc.sv
// MSB-aligned bit accumulator for the LZW packer. A pop shifts one beat out
// of the top; a push ORs the masked code in directly below the bits still
// held after that shift. Bits below the fill level are always zero.
module lzw_pack_acc
    import lzw_pkg::*;
#(
    parameter int MAX_CODE_W = LZW_MAX_CODE_W,
    parameter int OUT_W      = 8,
    parameter int ACC_W      = 32,
    parameter int FILL_W     = lzw_fill_w(32),
    parameter int CW_W       = $clog2(LZW_MAX_CODE_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [MAX_CODE_W-1:0] push_data,
    input  logic [CW_W-1:0]       push_w,
    input  logic                  pop,
    output logic [OUT_W-1:0]      beat_data,
    output logic [FILL_W-1:0]     fill
);
    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] ACC_W_F = FILL_W'(ACC_W);

    logic [ACC_W-1:0]      acc_r;
    logic [FILL_W-1:0]     fill_r;
    logic [ACC_W-1:0]      acc_shift_s;
    logic [ACC_W-1:0]      acc_next_s;
    logic [ACC_W-1:0]      code_ext_s;
    logic [MAX_CODE_W-1:0] mask_s;
    logic [FILL_W-1:0]     popped_s;
    logic [FILL_W-1:0]     fill_mid_s;
    logic [FILL_W-1:0]     fill_next_s;
    logic [FILL_W-1:0]     shift_amt_s;

    // Next accumulator: apply the beat shift first, then place the new code.
    always_comb begin
        acc_shift_s = acc_r;
        fill_mid_s  = fill_r;
        acc_next_s  = acc_r;
        fill_next_s = fill_r;
        mask_s      = {MAX_CODE_W{1'b0}};
        popped_s    = (fill_r < OUT_W_F) ? fill_r : OUT_W_F;

        if (pop) begin
            acc_shift_s = acc_r << OUT_W;
            fill_mid_s  = fill_r - popped_s;
        end else begin
            acc_shift_s = acc_r;
            fill_mid_s  = fill_r;
        end

        for (int i = 0; i < MAX_CODE_W; i++) begin
            mask_s[i] = (CW_W'(i) < push_w);
        end
        code_ext_s  = {{(ACC_W - MAX_CODE_W){1'b0}}, push_data & mask_s};
        shift_amt_s = ACC_W_F - fill_mid_s - FILL_W'(push_w);

        if (push) begin
            acc_next_s  = acc_shift_s | (code_ext_s << shift_amt_s);
            fill_next_s = fill_mid_s + FILL_W'(push_w);
        end else begin
            acc_next_s  = acc_shift_s;
            fill_next_s = fill_mid_s;
        end
    end

    // Accumulator and fill level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r  <= {ACC_W{1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else begin
            acc_r  <= acc_next_s;
            fill_r <= fill_next_s;
        end
    end

    assign beat_data = acc_r[ACC_W-1 -: OUT_W];
    assign fill      = fill_r;

endmodule

// File: rtl/lzw_code_packer.sv
// LZW code packer: packs 1..MAX_CODE_W-bit codes MSB-first into OUT_W-bit
// beats, with an explicit end-of-stream flush (zero padding, out_last) and a
// flush_done pulse. Define LZW_PACK_EOS_CODE_EN to append an all-ones
// terminator code (width of the last legal code) before the flush drains.
module lzw_code_packer
    import lzw_pkg::*;
#(
    parameter int MAX_CODE_W = LZW_MAX_CODE_W,
    parameter int OUT_W      = 8,
    parameter int ACC_W      = 32,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    lzw_code_packer_if.slave            bus,
    output logic [lzw_fill_w(ACC_W)-1:0] fill_cnt,
    output logic [CNT_W-1:0]            beat_cnt,
    output logic                        width_err
);
    localparam int FILL_W = lzw_fill_w(ACC_W);
    localparam int CW_W   = $clog2(MAX_CODE_W + 1);

    localparam logic [FILL_W-1:0] READY_LIMIT = FILL_W'(ACC_W - MAX_CODE_W);
    localparam logic [FILL_W-1:0] OUT_W_F     = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] FILL_ZERO   = {FILL_W{1'b0}};
    localparam logic [CW_W-1:0]   MAX_W_C     = CW_W'(MAX_CODE_W);
    localparam logic [CW_W-1:0]   W_ZERO      = {CW_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    if (!lzw_params_ok(MAX_CODE_W, OUT_W, ACC_W)) begin : g_param_check
        $error("lzw_code_packer: ACC_W must be at least MAX_CODE_W + OUT_W");
    end

    lzw_state_e            state_r;
    lzw_state_e            state_next_s;
    logic [FILL_W-1:0]     fill_s;
    logic [OUT_W-1:0]      beat_data_s;
    logic [CNT_W-1:0]      beat_cnt_r;
    logic                  width_err_r;
    logic                  code_ready_s;
    logic                  out_valid_s;
    logic                  out_last_s;
    logic                  code_fire_s;
    logic                  width_ok_s;
    logic                  pop_s;
    logic                  push_s;
    logic [MAX_CODE_W-1:0] push_data_s;
    logic [CW_W-1:0]       push_w_s;
`ifdef LZW_PACK_EOS_CODE_EN
    logic                  eos_push_s;
    logic [CW_W-1:0]       last_w_r;
`endif

    // Handshake qualifiers derived from registered state only.
    always_comb begin
        code_ready_s = 1'b0;
        out_valid_s  = 1'b0;
        out_last_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                code_ready_s = (fill_s <= READY_LIMIT);
                out_valid_s  = (fill_s >= OUT_W_F);
            end
`ifdef LZW_PACK_EOS_CODE_EN
            ST_EOS: begin
                out_valid_s = (fill_s >= OUT_W_F);
            end
`endif
            ST_FLUSH: begin
                out_valid_s = (fill_s != FILL_ZERO);
                out_last_s  = (fill_s != FILL_ZERO) && (fill_s <= OUT_W_F);
            end
            default: begin
                code_ready_s = 1'b0;
                out_valid_s  = 1'b0;
                out_last_s   = 1'b0;
            end
        endcase
    end

    assign code_fire_s = bus.code_valid && code_ready_s;
    assign width_ok_s  = (bus.code_width != W_ZERO) && (bus.code_width <= MAX_W_C);
    assign pop_s       = out_valid_s && bus.out_ready;

    // Stream control: RUN -> (EOS) -> FLUSH -> DONE -> RUN.
    always_comb begin
        state_next_s = state_r;
`ifdef LZW_PACK_EOS_CODE_EN
        eos_push_s   = 1'b0;
`endif
        case (state_r)
            ST_RUN: begin
                if (bus.flush_req) begin
`ifdef LZW_PACK_EOS_CODE_EN
                    state_next_s = ST_EOS;
`else
                    state_next_s = ST_FLUSH;
`endif
                end else begin
                    state_next_s = ST_RUN;
                end
            end
`ifdef LZW_PACK_EOS_CODE_EN
            ST_EOS: begin
                if (fill_s <= READY_LIMIT) begin
                    eos_push_s   = 1'b1;
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_EOS;
                end
            end
`endif
            ST_FLUSH: begin
                if (fill_s == FILL_ZERO) begin
                    state_next_s = ST_DONE;
                end else if (pop_s && out_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Select what goes into the accumulator: a legal accepted code or the terminator.
    always_comb begin
        push_data_s = bus.code_data;
        push_w_s    = bus.code_width;
        push_s      = code_fire_s && width_ok_s;
`ifdef LZW_PACK_EOS_CODE_EN
        if (eos_push_s) begin
            push_data_s = {MAX_CODE_W{1'b1}};
            push_w_s    = last_w_r;
            push_s      = 1'b1;
        end else begin
            push_data_s = bus.code_data;
            push_w_s    = bus.code_width;
            push_s      = code_fire_s && width_ok_s;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Beat counter and sticky illegal-width flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r  <= {CNT_W{1'b0}};
            width_err_r <= 1'b0;
        end else begin
            if (pop_s) begin
                beat_cnt_r <= beat_cnt_r + CNT_ONE;
            end
            if (code_fire_s && !width_ok_s) begin
                width_err_r <= 1'b1;
            end
        end
    end

`ifdef LZW_PACK_EOS_CODE_EN
    // Width of the most recent legal code, reused for the terminator.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_w_r <= MAX_W_C;
        end else if (code_fire_s && width_ok_s) begin
            last_w_r <= bus.code_width;
        end
    end
`endif

    lzw_pack_acc #(
        .MAX_CODE_W (MAX_CODE_W),
        .OUT_W      (OUT_W),
        .ACC_W      (ACC_W),
        .FILL_W     (FILL_W),
        .CW_W       (CW_W)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .push_w    (push_w_s),
        .pop       (pop_s),
        .beat_data (beat_data_s),
        .fill      (fill_s)
    );

    assign bus.code_ready = code_ready_s;
    assign bus.out_valid  = out_valid_s;
    assign bus.out_data   = beat_data_s;
    assign bus.out_last   = out_last_s;
    assign bus.flush_done = (state_r == ST_DONE);
    assign fill_cnt       = fill_s;
    assign beat_cnt       = beat_cnt_r;
    assign width_err      = width_err_r;

endmodule

// File: tb/tb_lzw_code_packer.sv
// Testbench for lzw_code_packer: a bit-queue reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
// Build with LZW_PACK_EOS_CODE_EN to exercise the terminator-code variant.
module tb_lzw_code_packer;
    import lzw_pkg::*;

    localparam int MCW  = LZW_MAX_CODE_W;
    localparam int OW   = 8;
    localparam int AW   = 32;
    localparam int CNTW = 16;
    localparam int FW   = $clog2(AW + 1);
    localparam int M_RUN = 0, M_EOS = 1, M_FLUSH = 2, M_DONE = 3;
`ifdef LZW_PACK_EOS_CODE_EN
    localparam bit EOS_EN = 1'b1;
`else
    localparam bit EOS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [FW-1:0]   fill_cnt;
    logic [CNTW-1:0] beat_cnt;
    logic            width_err;

    always #5 clk = ~clk;

    lzw_code_packer_if #(.MAX_CODE_W(MCW), .OUT_W(OW)) bus_if ();

    lzw_code_packer #(.MAX_CODE_W(MCW), .OUT_W(OW), .ACC_W(AW), .CNT_W(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .fill_cnt  (fill_cnt),
        .beat_cnt  (beat_cnt),
        .width_err (width_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the pending bit stream, earliest bit at the front.
    bit          mq[$];
    int          m_mode;
    int          m_last_w;
    logic [15:0] m_beats;
    bit          m_werr;
    bit          run_chk = 1'b0;

    // Log of beats actually consumed ({last, data}) and flush_done pulses.
    logic [8:0]  beat_log[$];
    int          done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode   = M_RUN;
        m_last_w = MCW;
        m_beats  = 16'd0;
        m_werr   = 1'b0;
    endtask

    // Per-cycle comparison against the model, then advance the model by one edge.
    always @(negedge clk) begin : compare
        int         sz;
        int         w;
        int         nxt;
        bit         e_rdy, e_vld, e_last, e_done, pop, push;
        logic [7:0] e_data;
        if (run_chk) begin
            sz     = mq.size();
            e_rdy  = (m_mode == M_RUN) && (sz <= AW - MCW);
            e_vld  = ((m_mode == M_RUN || m_mode == M_EOS) && sz >= OW) || (m_mode == M_FLUSH && sz > 0);
            e_last = (m_mode == M_FLUSH) && (sz > 0) && (sz <= OW);
            e_done = (m_mode == M_DONE);
            for (int i = 0; i < OW; i++) e_data[OW-1-i] = (i < sz) ? mq[i] : 1'b0;

            chk("code_ready", 32'(bus_if.code_ready), 32'(e_rdy));
            chk("out_valid",  32'(bus_if.out_valid),  32'(e_vld));
            chk("out_last",   32'(bus_if.out_last),   32'(e_last));
            chk("flush_done", 32'(bus_if.flush_done), 32'(e_done));
            chk("fill_cnt",   32'(fill_cnt),          32'(sz));
            chk("beat_cnt",   32'(beat_cnt),          32'(m_beats));
            chk("width_err",  32'(width_err),         32'(m_werr));
            if (e_vld) chk("out_data", 32'(bus_if.out_data), 32'(e_data));

            if (bus_if.out_valid && bus_if.out_ready) beat_log.push_back({bus_if.out_last, bus_if.out_data});
            if (bus_if.flush_done) done_cnt++;

            pop  = e_vld && bus_if.out_ready;
            push = e_rdy && bus_if.code_valid;
            if (rst) begin
                model_reset();
            end else begin
                nxt = m_mode;
                case (m_mode)
                    M_RUN:   if (bus_if.flush_req) nxt = EOS_EN ? M_EOS : M_FLUSH;
                    M_EOS:   if (sz <= AW - MCW) nxt = M_FLUSH;
                    M_FLUSH: if (sz == 0 || (pop && sz <= OW)) nxt = M_DONE;
                    default: nxt = M_RUN;
                endcase
                if (pop) begin
                    for (int i = 0; i < OW && mq.size() > 0; i++) void'(mq.pop_front());
                    m_beats++;
                end
                if (push) begin
                    w = int'(bus_if.code_width);
                    if (w >= 1 && w <= MCW) begin
                        for (int i = w - 1; i >= 0; i--) mq.push_back(bus_if.code_data[i]);
                        m_last_w = w;
                    end else begin
                        m_werr = 1'b1;
                    end
                end
                if (m_mode == M_EOS && sz <= AW - MCW) begin
                    for (int i = 0; i < m_last_w; i++) mq.push_back(1'b1);
                end
                m_mode = nxt;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus_if.code_valid = 1'b0;
        bus_if.code_data  = 13'd0;
        bus_if.code_width = 4'd0;
        bus_if.flush_req  = 1'b0;
    endtask

    task automatic push_code(input logic [12:0] d, input logic [3:0] w);
        bus_if.code_valid = 1'b1;
        bus_if.code_data  = d;
        bus_if.code_width = w;
        step();
        bus_if.code_valid = 1'b0;
    endtask

    task automatic do_flush();
        bus_if.flush_req = 1'b1;
        step();
        bus_if.flush_req = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int start;
        start = done_cnt;
        for (int i = 0; i < 60 && done_cnt == start; i++) step();
        chk(nm, 32'(done_cnt - start), 32'd1);
    endtask

    task automatic chk_beat(input string nm, input int idx, input logic [8:0] exp);
        if (idx < beat_log.size()) chk(nm, 32'(beat_log[idx]), 32'(exp));
        else chk(nm, 32'hdead, 32'(exp));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int d0;
        int nlast;
        model_reset();
        set_idle();
        bus_if.out_ready = 1'b1;
        rst = 1'b1;
        run_chk = 1'b1;

        // Reset
        repeat (3) step();
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_fill",      32'(fill_cnt),         32'd0);
        chk("rst_beat_cnt",  32'(beat_cnt),         32'd0);
        chk("rst_width_err", 32'(width_err),        32'd0);
        rst = 1'b0;
        step();
        chk("rst_code_ready", 32'(bus_if.code_ready), 32'd1);

`ifndef LZW_PACK_EOS_CODE_EN
        // Single 13-bit code, then flush
        beat_log.delete();
        push_code(13'h1555, 4'd13);
        chk("single_first_beat", 32'(bus_if.out_data), 32'h0AA);
        step();
        chk("single_fill_after_pop", 32'(fill_cnt), 32'd5);
        do_flush();
        chk("single_pad_beat", 32'(bus_if.out_data), 32'h0A8);
        chk("single_pad_last", 32'(bus_if.out_last), 32'd1);
        wait_done("single_done");
        chk("single_nbeats", 32'(beat_log.size()), 32'd2);
        chk_beat("single_log0", 0, {1'b0, 8'hAA});
        chk_beat("single_log1", 1, {1'b1, 8'hA8});

        // Two 9-bit codes, then flush
        beat_log.delete();
        push_code(13'h1FF, 4'd9);
        push_code(13'h000, 4'd9);
        do_flush();
        wait_done("w9_done");
        chk("w9_nbeats", 32'(beat_log.size()), 32'd3);
        chk_beat("w9_log0", 0, {1'b0, 8'hFF});
        chk_beat("w9_log1", 1, {1'b0, 8'h80});
        chk_beat("w9_log2", 2, {1'b1, 8'h00});
        chk("w9_beat_cnt", 32'(beat_cnt), 32'd5);
`endif

        // Backpressure
        bus_if.out_ready = 1'b0;
        push_code(13'h1FFF, 4'd13);
        push_code(13'h1FFF, 4'd13);
        chk("bp_fill",       32'(fill_cnt),          32'd26);
        chk("bp_code_ready", 32'(bus_if.code_ready), 32'd0);
        repeat (3) step();
        chk("bp_hold_data",  32'(bus_if.out_data),   32'h0FF);
        chk("bp_hold_valid", 32'(bus_if.out_valid),  32'd1);
        bus_if.out_ready = 1'b1;
        step();
        chk("bp_release_fill",  32'(fill_cnt),          32'd18);
        chk("bp_release_ready", 32'(bus_if.code_ready), 32'd1);
        repeat (2) step();
        do_flush();
        wait_done("bp_done");

`ifndef LZW_PACK_EOS_CODE_EN
        // Flush with nothing held
        beat_log.delete();
        do_flush();
        chk("empty_no_valid", 32'(bus_if.out_valid),  32'd0);
        chk("empty_no_done1", 32'(bus_if.flush_done), 32'd0);
        step();
        chk("empty_done2", 32'(bus_if.flush_done), 32'd1);
        step();
        chk("empty_done_pulse", 32'(bus_if.flush_done), 32'd0);
        chk("empty_nbeats", 32'(beat_log.size()), 32'd0);
`endif

        // Illegal widths
        push_code(13'h0005, 4'd0);
        chk("w0_fill", 32'(fill_cnt),  32'd0);
        chk("w0_err",  32'(width_err), 32'd1);
        step();
        chk("w0_sticky", 32'(width_err), 32'd1);
        push_code(13'h1ABC, 4'd14);
        chk("w14_fill", 32'(fill_cnt), 32'd0);

        // Reset in the middle of a flush
        bus_if.out_ready = 1'b0;
        push_code(13'h1FFF, 4'd13);
        do_flush();
        repeat (2) step();
        beat_log.delete();
        d0 = done_cnt;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (5) step();
        nlast = 0;
        foreach (beat_log[i]) if (beat_log[i][8]) nlast++;
        chk("rstflush_no_last", 32'(nlast), 32'd0);
        chk("rstflush_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rstflush_fill",    32'(fill_cnt),   32'd0);
        chk("rstflush_err_clr", 32'(width_err),  32'd0);

`ifdef LZW_PACK_EOS_CODE_EN
        // Terminator code uses the last legal width
        beat_log.delete();
        push_code(13'h000, 4'd10);
        do_flush();
        wait_done("eos_done");
        chk("eos_nbeats", 32'(beat_log.size()), 32'd3);
        chk_beat("eos_log0", 0, {1'b0, 8'h00});
        chk_beat("eos_log1", 1, {1'b0, 8'h3F});
        chk_beat("eos_log2", 2, {1'b1, 8'hF0});
`endif

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            bus_if.code_valid = ($urandom_range(0, 9) < 6);
            bus_if.code_data  = 13'($urandom);
            if ($urandom_range(0, 40) == 0) bus_if.code_width = 4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(14, 15));
            else bus_if.code_width = 4'($urandom_range(1, 13));
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            bus_if.flush_req = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;
        set_idle();
        bus_if.out_ready = 1'b1;
        repeat (8) step();
        do_flush();
        wait_done("final_done");
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
